deconv_kernel_sram_bank_interface: RTL and testbench

//  Multi-bank successor to the single-bank kernel-magnitude SRAM interface. The estimator streams

---
 rtl/deconv_sram_pkg.sv | 20 ++
 rtl/deconv_sram_bank_ring_ctrl.sv | 82 ++++++++
 rtl/ram_sync_1rw1r.sv | 24 ++
 rtl/deconv_kernel_sram_bank_interface.sv | 150 +++++++++++++++
 tb/tb_deconv_kernel_sram_bank_interface.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/deconv_sram_pkg.sv
// Shared types and constants for the multi-bank deconv kernel-magnitude SRAM interface.
// DECONV_SRAM_RDATA_REG_EN selects the registered-rdata variant (read latency 2).
package deconv_sram_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_e;

    localparam int DEFAULT_DEPTH      = 2048;
    localparam int DEFAULT_DATA_WIDTH = 16;

`ifdef DECONV_SRAM_RDATA_REG_EN
    localparam int RD_LATENCY = 2;
`else
    localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/deconv_sram_bank_ring_ctrl.sv
// Bank ring bookkeeping: per-bank state and length, write/read bank pointers, write address.
//   state        | meaning
//   BANK_EMPTY   | free, may become the write bank
//   BANK_FILLING | write bank has accepted at least one word of an uncommitted frame
//   BANK_FULL    | committed frame, readable until released
module deconv_sram_bank_ring_ctrl
    import deconv_sram_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_WIDTH = 12,
    parameter int BANK_W     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic                  wr_commit,
    input  logic                  rd_release,
    output logic                  wr_accept,
    output logic [ADDR_WIDTH-2:0] wr_ptr,
    output logic [BANK_W-1:0]     wbank,
    output logic [BANK_W-1:0]     rbank,
    output logic                  wr_full,
    output logic                  wr_overflow,
    output logic                  rd_avail,
    output logic [ADDR_WIDTH-1:0] rd_len
);

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
    localparam logic [BANK_W-1:0]     LAST_BANK = BANK_W'(NUM_BANKS - 1);

    bank_state_e           state [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] len   [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] wadr;
    logic [ADDR_WIDTH-1:0] wcount;
    logic                  commit_go;
    logic                  release_go;

    function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
        return (b == LAST_BANK) ? '0 : b + BANK_W'(1);
    endfunction

    assign wr_accept  = wen && (state[wbank] != BANK_FULL) && (wadr < DEPTH_A);
    // A word accepted in the commit cycle belongs to the frame being committed.
    assign wcount     = wadr + ADDR_WIDTH'(wr_accept);
    assign commit_go  = wr_commit && (wcount != '0);
    assign release_go = rd_release && (state[rbank] == BANK_FULL);
    assign rd_avail   = (state[rbank] == BANK_FULL);
    assign rd_len     = len[rbank];
    assign wr_full    = (wadr == DEPTH_A) || (state[wbank] == BANK_FULL);
    assign wr_ptr     = wadr[ADDR_WIDTH-2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbank       <= '0;
            rbank       <= '0;
            wadr        <= '0;
            wr_overflow <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                state[b] <= BANK_EMPTY;
                len[b]   <= '0;
            end
        end else begin
            if (wen && !wr_accept) wr_overflow <= 1'b1;
            if (commit_go) begin
                state[wbank] <= BANK_FULL;
                len[wbank]   <= wcount;
                wbank        <= bank_inc(wbank);
                wadr         <= '0;
            end else if (wr_accept) begin
                state[wbank] <= BANK_FILLING;
                wadr         <= wcount;
            end
            // rbank always points at a FULL bank here, so it never collides with the write bank.
            if (release_go) begin
                state[rbank] <= BANK_EMPTY;
                rbank        <= bank_inc(rbank);
            end
        end
    end

endmodule

// File: rtl/ram_sync_1rw1r.sv
// Synchronous single-clock RAM with one write-capable port and one read port.
// The rw port is used write-only by the bank interface; reads go through the r port.
module ram_sync_1rw1r #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 2048,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic [AW-1:0]         wadr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [AW-1:0]         radr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) mem[wadr] <= wdata;
        if (ren) rdata <= mem[radr];
    end

endmodule

// File: rtl/deconv_kernel_sram_bank_interface.sv
// Multi-bank kernel-magnitude SRAM ring between the estimator and the deconv datapath.
// DECONV_SRAM_RDATA_REG_EN adds an output register on rdata/rvalid (read latency 2).
module deconv_kernel_sram_bank_interface
    import deconv_sram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH) + 1,
    parameter int NUM_BANKS  = 2,
    parameter int BANK_W     = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    input  logic                  wr_commit,
    output logic                  wr_full,
    output logic                  wr_overflow,
    output logic                  rd_avail,
    output logic [ADDR_WIDTH-1:0] rd_len,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-2:0] radr,
    input  logic                  rd_release,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  debug,
    input  logic                  debug_read_trig,
    output logic                  debug_wrap
);

    localparam int              AW        = ADDR_WIDTH - 1;
    localparam logic [AW-1:0]   LAST_ADR  = AW'(DEPTH - 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    logic                  wr_accept;
    logic [AW-1:0]         wr_ptr;
    logic [BANK_W-1:0]     wbank;
    logic [BANK_W-1:0]     rbank;
    logic                  dbg_go;
    logic                  cons_go;
    logic                  cons_zero;
    logic [BANK_W-1:0]     dbg_bank;
    logic [AW-1:0]         dbg_adr;
    logic [AW-1:0]         ram_radr;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic                  rd_pend;
    logic                  rd_zero;
    logic [BANK_W-1:0]     rd_sel;
    logic [DATA_WIDTH-1:0] rd_word;

    deconv_sram_bank_ring_ctrl #(
        .DEPTH      (DEPTH),
        .NUM_BANKS  (NUM_BANKS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BANK_W     (BANK_W)
    ) u_ring_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .wen         (wen),
        .wr_commit   (wr_commit),
        .rd_release  (rd_release),
        .wr_accept   (wr_accept),
        .wr_ptr      (wr_ptr),
        .wbank       (wbank),
        .rbank       (rbank),
        .wr_full     (wr_full),
        .wr_overflow (wr_overflow),
        .rd_avail    (rd_avail),
        .rd_len      (rd_len)
    );

    assign dbg_go    = debug && debug_read_trig;
    assign cons_go   = ren && rd_avail && !debug;
    assign cons_zero = ({1'b0, radr} >= rd_len);
    assign ram_radr  = dbg_go ? dbg_adr : radr;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic bank_wen;
        logic bank_ren;

        assign bank_wen = wr_accept && (wbank == BANK_W'(b));
        assign bank_ren = dbg_go ? (dbg_bank == BANK_W'(b))
                                 : (cons_go && !cons_zero && (rbank == BANK_W'(b)));

        ram_sync_1rw1r #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AW         (AW)
        ) u_ram (
            .clk   (clk),
            .wen   (bank_wen),
            .wadr  (wr_ptr),
            .wdata (wdata_in),
            .ren   (bank_ren),
            .radr  (ram_radr),
            .rdata (bank_rdata[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend    <= 1'b0;
            rd_zero    <= 1'b0;
            rd_sel     <= '0;
            dbg_bank   <= '0;
            dbg_adr    <= '0;
            debug_wrap <= 1'b0;
        end else begin
            rd_pend    <= dbg_go || cons_go;
            rd_zero    <= !dbg_go && cons_zero;
            rd_sel     <= dbg_go ? dbg_bank : rbank;
            debug_wrap <= 1'b0;
            if (!debug) begin
                dbg_bank <= '0;
                dbg_adr  <= '0;
            end else if (debug_read_trig) begin
                if (dbg_adr == LAST_ADR) begin
                    dbg_adr <= '0;
                    if (dbg_bank == LAST_BANK) begin
                        dbg_bank   <= '0;
                        debug_wrap <= 1'b1;
                    end else begin
                        dbg_bank <= dbg_bank + BANK_W'(1);
                    end
                end else begin
                    dbg_adr <= dbg_adr + AW'(1);
                end
            end
        end
    end

    // Gate the RAM output so rdata is 0 whenever no valid word is presented.
    assign rd_word = (rd_pend && !rd_zero) ? bank_rdata[rd_sel] : '0;

`ifdef DECONV_SRAM_RDATA_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rdata  <= rd_word;
            rvalid <= rd_pend;
        end
    end
`else
    assign rdata  = rd_word;
    assign rvalid = rd_pend;
`endif

endmodule

// File: tb/tb_deconv_kernel_sram_bank_interface.sv
// Directed bench for the multi-bank kernel SRAM interface; expected values are hand-derived
// and tracked in a small memory image of what the bench wrote.
module tb_deconv_kernel_sram_bank_interface;
    import deconv_sram_pkg::*;

    localparam int DEPTH = 2048;
    localparam int LAT   = RD_LATENCY;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wen = 1'b0;
    logic [15:0] wdata_in = '0;
    logic        wr_commit = 1'b0;
    logic        wr_full;
    logic        wr_overflow;
    logic        rd_avail;
    logic [11:0] rd_len;
    logic        ren = 1'b0;
    logic [10:0] radr = '0;
    logic        rd_release = 1'b0;
    logic [15:0] rdata;
    logic        rvalid;
    logic        debug = 1'b0;
    logic        debug_read_trig = 1'b0;
    logic        debug_wrap;

    int errs = 0;
    int checks = 0;

    logic [15:0] mem   [2][DEPTH];
    bit          known [2][DEPTH];

    always #5 clk = ~clk;

    deconv_kernel_sram_bank_interface dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wen             (wen),
        .wdata_in        (wdata_in),
        .wr_commit       (wr_commit),
        .wr_full         (wr_full),
        .wr_overflow     (wr_overflow),
        .rd_avail        (rd_avail),
        .rd_len          (rd_len),
        .ren             (ren),
        .radr            (radr),
        .rd_release      (rd_release),
        .rdata           (rdata),
        .rvalid          (rvalid),
        .debug           (debug),
        .debug_read_trig (debug_read_trig),
        .debug_wrap      (debug_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input int bank, input int start, input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wen      = 1'b1;
            wdata_in = base + 16'(i);
            mem[bank][start+i]   = base + 16'(i);
            known[bank][start+i] = 1'b1;
            tick();
        end
        wen = 1'b0;
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
    endtask

    task automatic release_bank();
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [10:0] a, input logic exp_v, input logic [15:0] exp_d);
        ren  = 1'b1;
        radr = a;
        tick();
        ren = 1'b0;
        chk({tag, "_t1_rvalid"}, rvalid, exp_v && (LAT == 1));
        repeat (LAT - 1) tick();
        chk({tag, "_rvalid"}, rvalid, exp_v);
        chk({tag, "_rdata"}, rdata, exp_d);
    endtask

    task automatic dbg_trig(input int idx, input bit wrap_chk, input logic wrap_exp);
        int b;
        int a;
        b = idx / DEPTH;
        a = idx % DEPTH;
        debug_read_trig = 1'b1;
        tick();
        debug_read_trig = 1'b0;
        if (wrap_chk) chk("debug_wrap", debug_wrap, wrap_exp);
        repeat (LAT - 1) tick();
        chk("dbg_rvalid", rvalid, 1);
        if (known[b][a]) chk("dbg_rdata", rdata, mem[b][a]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_full"}, wr_full, 0);
        chk({tag, "_wr_overflow"}, wr_overflow, 0);
        chk({tag, "_rd_avail"}, rd_avail, 0);
        chk({tag, "_rd_len"}, rd_len, 0);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_debug_wrap"}, debug_wrap, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) tick();
        chk_all_zero("rst");
        rst_n = 1'b1;
        tick();
        chk_all_zero("post_rst");

        // Short frame into bank0, random reads including out-of-range.
        write_words(0, 0, 16'h0100, 10);
        chk("filling_rd_avail", rd_avail, 0);
        commit();
        chk("commit_rd_avail", rd_avail, 1);
        chk("commit_rd_len", rd_len, 10);
        rd("rd_a3", 11'd3, 1, 16'h0103);
        rd("rd_oob", 11'd10, 1, 16'h0000);
        rd("rd_a0", 11'd0, 1, 16'h0100);

        // Fill bank1 to the brim, then one dropped word.
        write_words(1, 0, 16'h0000, 2047);
        chk("fill_2047_wr_full", wr_full, 0);
        write_words(1, 2047, 16'd2047, 1);
        chk("fill_2048_wr_full", wr_full, 1);
        chk("fill_2048_overflow", wr_overflow, 0);
        wen = 1'b1; wdata_in = 16'hDEAD; tick(); wen = 1'b0;
        chk("drop_overflow", wr_overflow, 1);
        commit();
        chk("both_full_wr_full", wr_full, 1);
        chk("both_full_rd_avail", rd_avail, 1);
        chk("both_full_rd_len", rd_len, 10);

        // Third frame has nowhere to go until bank0 is released.
        wen = 1'b1; wdata_in = 16'hBEEF; tick(); wen = 1'b0;
        chk("third_wr_full", wr_full, 1);
        release_bank();
        chk("rel0_rd_avail", rd_avail, 1);
        chk("rel0_rd_len", rd_len, 12'd2048);
        chk("rel0_wr_full", wr_full, 0);
        rd("rd_b1_last", 11'd2047, 1, 16'd2047);

        write_words(0, 0, 16'h0A00, 5);
        release_bank();
        chk("rel1_rd_avail", rd_avail, 0);
        rd("rd_noavail", 11'd0, 0, 16'h0000);
        commit();
        chk("resume_rd_avail", rd_avail, 1);
        chk("resume_rd_len", rd_len, 5);
        rd("rd_resume_a0", 11'd0, 1, 16'h0A00);
        rd("rd_resume_a4", 11'd4, 1, 16'h0A04);

        // Commit bank1 and release bank0 on the same edge.
        write_words(1, 0, 16'h0B00, 3);
        wr_commit = 1'b1; rd_release = 1'b1; tick(); wr_commit = 1'b0; rd_release = 1'b0;
        chk("same_rd_avail", rd_avail, 1);
        chk("same_rd_len", rd_len, 3);
        chk("same_wr_full", wr_full, 0);
        rd("rd_same", 11'd1, 1, 16'h0B01);
        write_words(0, 0, 16'hE000, 2);

        // Debug dump of both banks; consumer port is blocked.
        debug = 1'b1;
        tick();
        chk("dbg_rd_avail", rd_avail, 1);
        rd("rd_in_debug", 11'd3, 0, 16'h0000);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            dbg_trig(i, (i == DEPTH - 1) || (i >= 2 * DEPTH - 2), i == 2 * DEPTH - 1);
        end
        dbg_trig(0, 1, 0);
        debug = 1'b0;
        tick();

        // Reset in the middle of a 500-word frame.
        write_words(0, 2, 16'hC000, 498);
        chk("pre_rst_overflow", wr_overflow, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        tick();
        rst_n = 1'b1;
        tick();
        write_words(0, 0, 16'hD000, 4);
        commit();
        chk("post_mid_rst_rd_avail", rd_avail, 1);
        chk("post_mid_rst_rd_len", rd_len, 4);
        rd("rd_post_mid_rst", 11'd2, 1, 16'hD002);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
